cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Multicycle control sequencer for the lab RISC-V datapath. It consumes the 6-bit `op` code produced by the IR decoder and drives the instruction-fetch and data-memory handshakes, the IR/PC/register-file write enables, and the ALU/write-back operand selects, one instruction at a time. It sits beside the decoder and owns all architectural state updates in the CPU.

## Interface
- `MEM_TIMEOUT`, 255: max consecutive cycles waiting for `mem_ready` before trapping; 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: permits starting a new instruction.
- `op` in 6: decoder op code. 0–9 R-type, 10–18 I-ALU, 19–23 loads (LB, LH, LW, LBU, LHU), 24–26 stores (SB, SH, SW), 27 LUI, 28 AUIPC, 29–34 branches, 35 JAL, 36 JALR.
- `br_taken` in 1: branch comparison result from the ALU, valid in EXEC.
- `mem_ready` in 1: memory completes the current request.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store.
- `mem_size` out 2: 0 byte, 1 half, 2 word.
- `mem_unsigned` out 1: zero-extend load data.
- `ir_we` out 1: IR load.
- `pc_we` out 1: PC load.
- `pc_src` out 2: 0 PC+4, 1 PC+imm, 2 {ALU[31:1],0}.
- `rf_we` out 1: register-file write.
- `wb_sel` out 2: 0 ALU, 1 memory, 2 PC+4, 3 imm.
- `alu_a_sel` out 1: 0 rs1, 1 PC.
- `alu_b_sel` out 1: 0 rs2, 1 imm.
- `alu_op` out 6: latched op.
- `trap` out 1: sticky fault flag.
- `state` out 3: current state.
- `instret` out 32: retired-instruction count. Present only with `CPU_CTRL_PERF_EN`.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. The value 6 is unused and goes to TRAP.
- IDLE → FETCH when `run`=1.
- FETCH drives `mem_req`=1, `mem_we`=0, `mem_size`=2.
  - In the cycle `mem_ready`=1: `ir_we`=1, then go to DECODE.
- DECODE latches `op` into `alu_op`.
  - `op` > 36 → TRAP.
  - Otherwise → EXEC.
- EXEC:
  - `alu_a_sel`=1 for AUIPC, JAL and branches; 0 otherwise.
  - `alu_b_sel`=0 for R-type and branches; 1 otherwise.
  - Branch: `pc_we`=1, `pc_src`=`br_taken`?1:0, then return.
  - Load or store → MEM.
  - All others → WB.
- MEM holds `mem_req`=1 with `mem_we`=store, `mem_size` from the op, and `mem_unsigned`=1 for LBU/LHU. In the cycle `mem_ready`=1:
  - Store: `pc_we`=1, `pc_src`=0, then return.
  - Load → WB.
- WB: `rf_we`=1.
  - `wb_sel`: 1 for loads, 2 for JAL/JALR, 3 for LUI, 0 otherwise.
  - `pc_we`=1, with `pc_src` 1 for JAL, 2 for JALR, 0 otherwise.
  - Then return.
- "Return" means go to FETCH if `run`=1, else IDLE. `run` is never sampled mid-instruction.
- `mem_req`, once asserted, stays asserted with stable `mem_we`/`mem_size` until `mem_ready`. `mem_ready` outside FETCH/MEM is ignored.
- Wait counter: 8+ bits. Cleared on entry to FETCH/MEM; increments each cycle `mem_ready`=0. When it reaches `MEM_TIMEOUT` (≠0) → TRAP.
- TRAP: all enables and `mem_req` are 0, `trap`=1. Exit only via reset.
- Every enable not listed for a state is 0.

## Timing
- Reset (asynchronous, `reset`=0): `state`=IDLE. All outputs 0, including `alu_op`, `trap`, `instret` and the wait counter. Reset mid-instruction aborts immediately, with no PC/RF write.
- All outputs are combinational from registered state and `alu_op`, except `ir_we`, `pc_we` in EXEC, and MEM store/load completion, which also depend on `mem_ready`/`br_taken` in that cycle.
- Cycles per instruction with zero-wait memory:
  - Branch: 3.
  - ALU/LUI/AUIPC/JAL/JALR: 4.
  - Store: 4.
  - Load: 5.
- Each memory wait cycle adds 1.
- Timeout: with `MEM_TIMEOUT`=N, the state is TRAP on the cycle after N consecutive not-ready cycles.

## Configuration
- `CPU_CTRL_PERF_EN`: defined → 32-bit `instret` port.
  - Increments on each retiring cycle: the `pc_we`=1 cycle.
  - Wraps 0xFFFFFFFF → 0.
  - Cleared only by reset.
- Undefined → port and counter absent. All other behaviour is identical.

## Test plan
- Reset during MEM with `mem_req`=1 → next cycle `state`=0, all outputs 0, `trap`=0.
- `run`=1, zero-wait memory, `op`=0 (ADD) → states 1,2,3,5. `rf_we`=1 and `pc_we`=1 with `pc_src`=0 only in the WB cycle. `instret` increments by 1.
- `op`=21 (LW), `mem_ready` low 3 cycles in MEM → `mem_req` held 4 cycles with `mem_size`=2, `mem_we`=0, then WB with `wb_sel`=1. Total 8 cycles.
- `op`=29 (BEQ) with `br_taken`=1 → EXEC `pc_we`=1, `pc_src`=1. With `br_taken`=0 → `pc_src`=0. `rf_we` never 1.
- `op`=36 (JALR) → WB `wb_sel`=2, `pc_src`=2. `op`=40 → TRAP after DECODE, `trap`=1 until reset.
- `MEM_TIMEOUT`=4, `mem_ready` held 0 in FETCH → `state`=7 after 4 wait cycles. `mem_req` drops to 0.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle control sequencer for the lab RISC-V datapath.
// Runs one instruction at a time through IDLE/FETCH/DECODE/EXEC/MEM/WB and
// owns every architectural write enable (IR, PC, register file).
// Optional feature: define CPU_CTRL_PERF_EN to add the 32-bit instret counter.
//
// Memory handshake: mem_req is raised in FETCH/MEM and then held, together
// with mem_we/mem_size/mem_unsigned, until the cycle mem_ready=1; that cycle
// completes the transfer. mem_ready in any other state is ignored. A request
// left unanswered for MEM_TIMEOUT consecutive cycles (0 = never) traps.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [5:0]  alu_op,
  output logic        trap,
  output logic [2:0]  state
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  // Wait counter is at least 8 bits, wider only if the timeout needs it.
  localparam int            CW     = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TMO    = CW'(MEM_TIMEOUT);
  localparam bit            TMO_EN = (MEM_TIMEOUT != 0);

  state_e        state_q, state_d;
  logic [5:0]    alu_op_q, alu_op_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] wait_inc;
  logic          timeout_hit;
  state_e        ret_state;

  // Op classes, always taken from the latched op so they are stable after DECODE.
  logic is_rtype, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
  assign is_rtype  = (alu_op_q <= 6'd9);
  assign is_load   = (alu_op_q >= 6'd19) && (alu_op_q <= 6'd23);
  assign is_store  = (alu_op_q >= 6'd24) && (alu_op_q <= 6'd26);
  assign is_lui    = (alu_op_q == 6'd27);
  assign is_auipc  = (alu_op_q == 6'd28);
  assign is_branch = (alu_op_q >= 6'd29) && (alu_op_q <= 6'd34);
  assign is_jal    = (alu_op_q == 6'd35);
  assign is_jalr   = (alu_op_q == 6'd36);

  assign wait_inc    = wait_q + CW'(1);
  assign timeout_hit = TMO_EN && (wait_inc == TMO);
  // run is only looked at when an instruction retires (or in IDLE).
  assign ret_state   = run ? S_FETCH : S_IDLE;

  // Next-state, op latch and wait counter (counter is zero unless a request is still pending).
  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    wait_d   = '0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
        else                  wait_d  = wait_inc;
      end
      S_DECODE: begin
        alu_op_d = op;
        state_d  = (op > 6'd36) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (is_branch)                state_d = ret_state;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)        state_d = is_store ? ret_state : S_WB;
        else if (timeout_hit) state_d = S_TRAP;
        else                  wait_d  = wait_inc;
      end
      S_WB:     state_d = ret_state;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Control outputs decoded from the current state and latched op.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_size = 2'd2;
        ir_we    = mem_ready;
      end
      S_EXEC: begin
        alu_a_sel = is_auipc || is_jal || is_branch;
        alu_b_sel = !(is_rtype || is_branch);
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_we       = is_store;
        mem_unsigned = (alu_op_q == 6'd22) || (alu_op_q == 6'd23);
        if ((alu_op_q == 6'd21) || (alu_op_q == 6'd26))
          mem_size = 2'd2;
        else if ((alu_op_q == 6'd20) || (alu_op_q == 6'd23) || (alu_op_q == 6'd25))
          mem_size = 2'd1;
        else
          mem_size = 2'd0;
        pc_we = is_store && mem_ready;
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (is_load)                wb_sel = 2'd1;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        else if (is_lui)            wb_sel = 2'd3;
        else                        wb_sel = 2'd0;
        if (is_jal)       pc_src = 2'd1;
        else if (is_jalr) pc_src = 2'd2;
        else              pc_src = 2'd0;
      end
      default: ;
    endcase
  end

  // Sequencer state registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      alu_op_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      wait_q   <= wait_d;
    end
  end

  assign state  = state_q;
  assign alu_op = alu_op_q;
  assign trap   = (state_q == S_TRAP);

`ifdef CPU_CTRL_PERF_EN
  logic [31:0] instret_q, instret_d;
  assign instret_d = instret_q + (pc_we ? 32'd1 : 32'd0);

  // Retired-instruction counter: one count per PC write, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm. Instructions are described at the level of
// "op, fetch waits, memory waits, branch outcome, run afterwards"; a
// reference model expands each into the per-cycle outputs it must produce.
module tb_cpu_ctrl_fsm;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  op;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_unsigned, ir_we, pc_we, rf_we;
  logic        alu_a_sel, alu_b_sel, trap;
  logic [1:0]  mem_size, pc_src, wb_sel;
  logic [5:0]  alu_op;
  logic [2:0]  state;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] instret;
`endif

  cpu_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .op(op), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .trap(trap), .state(state)
`ifdef CPU_CTRL_PERF_EN
    , .instret(instret)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // One cycle: inputs to apply plus every output expected in that cycle.
  typedef struct packed {
    logic        run;
    logic [5:0]  op;
    logic        br_taken;
    logic        mem_ready;
    logic        chk_sel;
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [5:0]  alu_op;
    logic        trap;
    logic [31:0] instret;
  } cyc_t;

  cyc_t        exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [5:0]  m_alu_op;
  logic [31:0] m_instret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A cycle with random don't-care inputs and all outputs idle.
  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c           = '0;
    c.run       = 1'($urandom_range(0, 1));
    c.op        = 6'($urandom_range(0, 63));
    c.br_taken  = 1'($urandom_range(0, 1));
    c.mem_ready = 1'($urandom_range(0, 1));
    c.state     = st;
    c.alu_op    = m_alu_op;
    c.instret   = m_instret;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    exp_q.push_back(c);
    if (c.pc_we) m_instret = m_instret + 32'd1;
  endtask

  task automatic push_trap();
    cyc_t c;
    for (int k = 0; k < 3; k++) begin
      c = blank(3'd7);
      c.trap = 1'b1;
      push(c);
    end
  endtask

  // n idle cycles with run low, then one with run high that starts a fetch.
  task automatic gen_idle(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = blank(3'd0);
      c.run = 1'b0;
      push(c);
    end
    c = blank(3'd0);
    c.run = 1'b1;
    push(c);
  endtask

  task automatic gen_instr(input logic [5:0] o, input int wf, input int wm,
                           input bit taken, input bit run_next, output bit trapped);
    cyc_t c;
    bit ld, st, br;
    ld = (o >= 19) && (o <= 23);
    st = (o >= 24) && (o <= 26);
    br = (o >= 29) && (o <= 34);
    trapped = 1'b0;
    // fetch: wait cycles, then the accepted one
    for (int k = 0; k < wf && k < TMO; k++) begin
      c = blank(3'd1);
      c.mem_ready = 1'b0; c.mem_req = 1'b1; c.mem_size = 2'd2;
      push(c);
    end
    if (wf >= TMO) begin push_trap(); trapped = 1'b1; return; end
    c = blank(3'd1);
    c.mem_ready = 1'b1; c.mem_req = 1'b1; c.mem_size = 2'd2; c.ir_we = 1'b1;
    push(c);
    // decode
    c = blank(3'd2);
    c.op = o;
    push(c);
    m_alu_op = o;
    if (o > 36) begin push_trap(); trapped = 1'b1; return; end
    // exec
    c = blank(3'd3);
    c.chk_sel   = 1'b1;
    c.alu_a_sel = (o == 28) || (o == 35) || br;
    c.alu_b_sel = !((o <= 9) || br);
    c.br_taken  = taken;
    if (br) begin
      c.pc_we  = 1'b1;
      c.pc_src = taken ? 2'd1 : 2'd0;
      c.run    = run_next;
      push(c);
      return;
    end
    push(c);
    // memory access
    if (ld || st) begin
      for (int k = 0; k < wm && k < TMO; k++) begin
        c = blank(3'd4);
        c.mem_ready = 1'b0; c.mem_req = 1'b1; c.mem_we = st;
        c.mem_size = ((o == 21) || (o == 26)) ? 2'd2 :
                     ((o == 20) || (o == 23) || (o == 25)) ? 2'd1 : 2'd0;
        c.mem_unsigned = (o == 22) || (o == 23);
        push(c);
      end
      if (wm >= TMO) begin push_trap(); trapped = 1'b1; return; end
      c = blank(3'd4);
      c.mem_ready = 1'b1; c.mem_req = 1'b1; c.mem_we = st;
      c.mem_size = ((o == 21) || (o == 26)) ? 2'd2 :
                   ((o == 20) || (o == 23) || (o == 25)) ? 2'd1 : 2'd0;
      c.mem_unsigned = (o == 22) || (o == 23);
      if (st) begin
        c.pc_we = 1'b1;
        c.run   = run_next;
        push(c);
        return;
      end
      push(c);
    end
    // write-back
    c = blank(3'd5);
    c.rf_we  = 1'b1;
    c.pc_we  = 1'b1;
    c.wb_sel = ld ? 2'd1 : ((o == 35) || (o == 36)) ? 2'd2 : (o == 27) ? 2'd3 : 2'd0;
    c.pc_src = (o == 35) ? 2'd1 : (o == 36) ? 2'd2 : 2'd0;
    c.run    = run_next;
    push(c);
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic play(input bit stop_at_mem);
    cyc_t c;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      @(posedge clk); #1;
      run = c.run; op = c.op; br_taken = c.br_taken; mem_ready = c.mem_ready;
      #1;
      chk("state", state, c.state);
      chk("mem_req", mem_req, c.mem_req);
      chk("mem_we", mem_we, c.mem_we);
      chk("mem_size", mem_size, c.mem_size);
      chk("mem_unsigned", mem_unsigned, c.mem_unsigned);
      chk("ir_we", ir_we, c.ir_we);
      chk("pc_we", pc_we, c.pc_we);
      chk("pc_src", pc_src, c.pc_src);
      chk("rf_we", rf_we, c.rf_we);
      chk("wb_sel", wb_sel, c.wb_sel);
      if (c.chk_sel) begin
        chk("alu_a_sel", alu_a_sel, c.alu_a_sel);
        chk("alu_b_sel", alu_b_sel, c.alu_b_sel);
      end
      chk("alu_op", alu_op, c.alu_op);
      chk("trap", trap, c.trap);
`ifdef CPU_CTRL_PERF_EN
      chk("instret", instret, c.instret);
`endif
      if (stop_at_mem && (c.state == 3'd4)) return;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, state, 0);
    chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".mem_size"}, mem_size, 0);
    chk({tag, ".mem_unsigned"}, mem_unsigned, 0);
    chk({tag, ".ir_we"}, ir_we, 0);
    chk({tag, ".pc_we"}, pc_we, 0);
    chk({tag, ".pc_src"}, pc_src, 0);
    chk({tag, ".rf_we"}, rf_we, 0);
    chk({tag, ".wb_sel"}, wb_sel, 0);
    chk({tag, ".alu_a_sel"}, alu_a_sel, 0);
    chk({tag, ".alu_b_sel"}, alu_b_sel, 0);
    chk({tag, ".alu_op"}, alu_op, 0);
    chk({tag, ".trap"}, trap, 0);
`ifdef CPU_CTRL_PERF_EN
    chk({tag, ".instret"}, instret, 0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0; mem_ready = 1'b0; br_taken = 1'b0; op = 6'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    m_alu_op  = 6'd0;
    m_instret = 32'd0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit tr;
    int wf, wm;
    logic [5:0] o;
    reset = 1'b0; run = 1'b0; op = 6'd0; br_taken = 1'b0; mem_ready = 1'b0;
    m_alu_op = 6'd0; m_instret = 32'd0;
    do_reset();

    // ADD, LW with 3 memory waits, BEQ taken / not taken, JALR, illegal op
    gen_idle(0);
    gen_instr(6'd0, 0, 0, 1'b0, 1'b1, tr);
    gen_instr(6'd21, 0, 3, 1'b0, 1'b1, tr);
    gen_instr(6'd29, 0, 0, 1'b1, 1'b1, tr);
    gen_instr(6'd29, 1, 0, 1'b0, 1'b0, tr);
    gen_idle(1);
    gen_instr(6'd36, 0, 0, 1'b0, 1'b1, tr);
    gen_instr(6'd40, 0, 0, 1'b0, 1'b0, tr);
    play(1'b0);
    do_reset();

    // fetch never answered: trap after TMO wait cycles
    gen_idle(0);
    gen_instr(6'd0, TMO, 0, 1'b0, 1'b0, tr);
    play(1'b0);
    do_reset();

    // reset arriving while a load is waiting in MEM
    gen_idle(0);
    gen_instr(6'd21, 0, 3, 1'b0, 1'b1, tr);
    play(1'b1);
    reset = 1'b0;
    #1;
    chk_zero("rst_mem");
    do_reset();

    // randomized instruction stream
    gen_idle(0);
    for (int i = 0; i < 80; i++) begin
      o  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(37, 63)) : 6'($urandom_range(0, 36));
      wf = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
      wm = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        gen_instr(o, wf, wm, 1'($urandom_range(0, 1)), 1'b0, tr);
        if (!tr) gen_idle($urandom_range(0, 2));
      end else begin
        gen_instr(o, wf, wm, 1'($urandom_range(0, 1)), 1'b1, tr);
      end
      play(1'b0);
      if (tr) begin
        do_reset();
        gen_idle(0);
      end
    end
    play(1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
